lht_ctrl: RTL and testbench

- Controller for the 256x8 dual-port local history table (LHT) SRAM in the branch predictor.
- Owns both SRAM ports:
  - Port 0: read-only, serves fetch-stage history lookups.
  - Port 1: initialization sweep after reset, then read-modify-write shift updates from branch resolution.
- Bypasses in-flight writes so lookups never return stale history. The SRAM has no reset, so this block zero-fills it before enabling traffic.

---
 rtl/lht_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_lht_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lht_ctrl.sv
// lht_ctrl: controller for the local history table SRAM (dual port).
// Port 0 serves fetch lookups; port 1 zero-fills the table after reset and
// then does read-modify-write history shifts for resolved branches.
// A write still in flight to the SRAM is forwarded to a lookup that was
// accepted at the same edge the write was issued.
// Optional: define LHT_CTRL_PERF_EN to add 32-bit lookup/update/forward counters.
module lht_ctrl #(
  parameter int IDX_WIDTH  = 8,
  parameter int HIST_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  input  logic                  lookup_valid,
  input  logic [IDX_WIDTH-1:0]  lookup_idx,
  output logic                  lookup_ready,
  output logic                  resp_valid,
  output logic [HIST_WIDTH-1:0] resp_hist,
  input  logic                  upd_valid,
  input  logic [IDX_WIDTH-1:0]  upd_idx,
  input  logic                  upd_taken,
  output logic                  upd_ready,
  output logic                  csb0,
  output logic                  web0,
  output logic [IDX_WIDTH-1:0]  addr0,
  output logic [HIST_WIDTH-1:0] din0,
  input  logic [HIST_WIDTH-1:0] dout0,
  output logic                  csb1,
  output logic                  web1,
  output logic [IDX_WIDTH-1:0]  addr1,
  output logic [HIST_WIDTH-1:0] din1,
  input  logic [HIST_WIDTH-1:0] dout1
`ifdef LHT_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_lookup_cnt,
  output logic [31:0]           perf_upd_cnt,
  output logic [31:0]           perf_fwd_cnt
`endif
);

  typedef enum logic {S_INIT, S_RUN} state_t;
  typedef enum logic {U_IDLE, U_WR}  ustate_t;

  typedef struct packed {
    logic                  vld;
    logic [IDX_WIDTH-1:0]  idx;
    logic [HIST_WIDTH-1:0] data;
  } wr_t;

  localparam logic [IDX_WIDTH-1:0] IDX_MAX = '1;

  state_t                state, state_nx;
  ustate_t               ustate, ustate_nx;
  logic [IDX_WIDTH-1:0]  init_cnt;
  logic [IDX_WIDTH-1:0]  u_idx;
  logic                  u_taken;
  wr_t                   wr_q;
  logic [IDX_WIDTH-1:0]  lk_idx_q;
  logic [HIST_WIDTH-1:0] new_hist;
  logic                  lk_acc, upd_acc, wr_issue, fwd_sel;

  // Shift the resolved direction in at the LSB; the oldest bit falls off the top.
  assign new_hist = HIST_WIDTH'({dout1, u_taken});

  assign lk_acc   = !rst && (state == S_RUN) && lookup_valid;
  assign upd_acc  = !rst && (state == S_RUN) && (ustate == U_IDLE) && upd_valid;
  assign wr_issue = !rst && (state == S_RUN) && (ustate == U_WR);

  // Response data is stale in the SRAM only when the write to the same index
  // was issued at the accept edge; wr_q holds it until it commits.
  assign fwd_sel   = resp_valid && wr_q.vld && (lk_idx_q == wr_q.idx);
  assign resp_hist = fwd_sel ? wr_q.data : dout0;
  assign din0      = '0;

  // Next-state and SRAM command decode; everything idles while rst is high.
  always_comb begin
    state_nx     = state;
    ustate_nx    = ustate;
    init_done    = 1'b0;
    lookup_ready = 1'b0;
    upd_ready    = 1'b0;
    csb0         = 1'b1;
    web0         = 1'b1;
    addr0        = '0;
    csb1         = 1'b1;
    web1         = 1'b1;
    addr1        = '0;
    din1         = '0;
    if (!rst) begin
      case (state)
        S_INIT: begin
          csb1  = 1'b0;
          web1  = 1'b0;
          addr1 = init_cnt;
          if (init_cnt == IDX_MAX) state_nx = S_RUN;
        end
        default: begin
          init_done    = 1'b1;
          lookup_ready = 1'b1;
          if (lookup_valid) begin
            csb0  = 1'b0;
            addr0 = lookup_idx;
          end
          case (ustate)
            U_IDLE: begin
              upd_ready = 1'b1;
              if (upd_valid) begin
                csb1      = 1'b0;
                addr1     = upd_idx;
                ustate_nx = U_WR;
              end
            end
            default: begin
              csb1      = 1'b0;
              web1      = 1'b0;
              addr1     = u_idx;
              din1      = new_hist;
              ustate_nx = U_IDLE;
            end
          endcase
        end
      endcase
    end
  end

  // Top-level and update FSM state, zero-fill counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INIT;
      ustate   <= U_IDLE;
      init_cnt <= '0;
    end else begin
      state  <= state_nx;
      ustate <= ustate_nx;
      if (state == S_INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  // Latch the accepted update, and the write in flight for forwarding.
  always_ff @(posedge clk) begin
    if (rst) begin
      u_idx   <= '0;
      u_taken <= 1'b0;
      wr_q    <= '0;
    end else begin
      if (upd_acc) begin
        u_idx   <= upd_idx;
        u_taken <= upd_taken;
      end
      wr_q.vld <= wr_issue;
      if (wr_issue) begin
        wr_q.idx  <= u_idx;
        wr_q.data <= new_hist;
      end
    end
  end

  // Lookup response pulse and the index it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      lk_idx_q   <= '0;
    end else begin
      resp_valid <= lk_acc;
      if (lk_acc) lk_idx_q <= lookup_idx;
    end
  end

`ifdef LHT_CTRL_PERF_EN
  // Free-running event counters, wrapping at 2**32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lookup_cnt <= '0;
      perf_upd_cnt    <= '0;
      perf_fwd_cnt    <= '0;
    end else begin
      if (lk_acc)   perf_lookup_cnt <= perf_lookup_cnt + 32'd1;
      if (wr_issue) perf_upd_cnt    <= perf_upd_cnt + 32'd1;
      if (fwd_sel)  perf_fwd_cnt    <= perf_fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lht_ctrl.sv
// tb_lht_ctrl: self-checking bench for lht_ctrl with a behavioural 256x8
// dual-port SRAM model and a lookup response scoreboard.
module tb_lht_ctrl;

  logic       clk, rst;
  logic       init_done, lookup_valid, lookup_ready, resp_valid;
  logic [7:0] lookup_idx, resp_hist;
  logic       upd_valid, upd_taken, upd_ready;
  logic [7:0] upd_idx;
  logic       csb0, web0, csb1, web1;
  logic [7:0] addr0, din0, dout0, addr1, din1, dout1;
`ifdef LHT_CTRL_PERF_EN
  logic [31:0] perf_lookup_cnt, perf_upd_cnt, perf_fwd_cnt;
`endif

  lht_ctrl #(.IDX_WIDTH(8), .HIST_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .lookup_valid(lookup_valid), .lookup_idx(lookup_idx), .lookup_ready(lookup_ready),
    .resp_valid(resp_valid), .resp_hist(resp_hist),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_ready(upd_ready),
    .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0),
    .csb1(csb1), .web1(web1), .addr1(addr1), .din1(din1), .dout1(dout1)
`ifdef LHT_CTRL_PERF_EN
    , .perf_lookup_cnt(perf_lookup_cnt), .perf_upd_cnt(perf_upd_cnt), .perf_fwd_cnt(perf_fwd_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1, "watchdog");
  end

  // SRAM model: a write issued at edge N commits at N+1; a read at N+1 sees it.
  logic [7:0] mem [256];
  int         wcnt [256];
  logic       p1_pend;
  logic [7:0] p1_a, p1_d;
  bit         cnt_en;
  int         bad55;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'hA5 ^ i[7:0];
      wcnt[i] = 0;
    end
    p1_pend = 1'b0;
    p1_a    = 8'h00;
    p1_d    = 8'h00;
    bad55   = 0;
    cnt_en  = 1'b0;
    dout0   = 8'h00;
    dout1   = 8'h00;
  end

  always @(posedge clk) begin
    if (p1_pend) mem[p1_a] <= p1_d;
    p1_pend <= 1'b0;
    if (!csb0 && web0)
      dout0 <= (p1_pend && p1_a == addr0) ? p1_d : mem[addr0];
    if (!csb1) begin
      if (web1) begin
        dout1 <= (p1_pend && p1_a == addr1) ? p1_d : mem[addr1];
      end else begin
        p1_pend <= 1'b1;
        p1_a    <= addr1;
        p1_d    <= din1;
        if (cnt_en) wcnt[addr1] <= wcnt[addr1] + 1;
        if (addr1 == 8'h55 && din1 != 8'h00) bad55 <= bad55 + 1;
      end
    end
  end

  int n_cmp = 0, n_bad = 0;
  int n_lk = 0, n_up = 0;
  logic [7:0] sb [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Response monitor: every resp_valid pulse pops one expected history.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL resp_unexpected: got resp 0x%0h want no response", resp_hist);
      end else begin
        chk("resp_hist", {24'h0, resp_hist}, {24'h0, sb.pop_front()});
      end
    end
  end

  task automatic do_lookup(input logic [7:0] idx, input logic [7:0] exp);
    lookup_valid = 1'b1;
    lookup_idx   = idx;
    sb.push_back(exp);
    n_lk++;
    @(negedge clk);
    lookup_valid = 1'b0;
  endtask

  task automatic do_update(input logic [7:0] idx, input logic tk);
    int w = 0;
    while (!upd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!upd_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL upd_ready_timeout: got ready=0 want ready=1");
    end else begin
      upd_valid = 1'b1;
      upd_idx   = idx;
      upd_taken = tk;
      n_up++;
      @(negedge clk);
      upd_valid = 1'b0;
    end
  endtask

  task automatic wait_init(input string nm);
    int cyc = 0;
    while (!init_done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 100) chk({nm, "_readys"}, {30'h0, lookup_ready, upd_ready}, 32'h0);
    end
    chk({nm, "_cycles"}, cyc, 256);
  endtask

  typedef struct {
    logic [7:0] idx;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [5:0] pat;
    int ok;

    vecs[0] = '{8'h10, 8'h07};
    vecs[1] = '{8'h22, 8'h01};
    vecs[2] = '{8'h31, 8'h01};
    vecs[3] = '{8'h44, 8'hFE};
    vecs[4] = '{8'h00, 8'h00};
    vecs[5] = '{8'hFF, 8'h00};
    vecs[6] = '{8'h30, 8'h00};

    // Reset with requests asserted: everything must stay idle.
    rst = 1'b1;
    lookup_valid = 1'b1; lookup_idx = 8'h12;
    upd_valid = 1'b1; upd_idx = 8'h34; upd_taken = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_csb", {30'h0, csb0, csb1}, 32'h3);
    chk("rst_web", {30'h0, web0, web1}, 32'h3);
    chk("rst_addr_din", {addr0, addr1, din1, 8'h00}, 32'h0);
    chk("rst_flags", {28'h0, init_done, lookup_ready, upd_ready, resp_valid}, 32'h0);
`ifdef LHT_CTRL_PERF_EN
    chk("rst_perf", perf_lookup_cnt | perf_upd_cnt | perf_fwd_cnt, 32'h0);
`endif

    // Zero-fill sweep.
    lookup_valid = 1'b0;
    upd_valid = 1'b0;
    cnt_en = 1'b1;
    rst = 1'b0;
    #1;
    chk("init_first_cmd", {22'h0, csb1, web1, addr1}, 32'h0);
    wait_init("init");
    @(negedge clk);
    cnt_en = 1'b0;
    ok = 0;
    for (int i = 0; i < 256; i++) if (wcnt[i] == 1 && mem[i] == 8'h00) ok++;
    chk("init_each_once_zero", ok, 256);

    do_lookup(8'h5A, 8'h00);
    chk("resp_latency", {31'h0, resp_valid}, 32'h1);

    // Updates as fast as upd_ready allows.
    upd_valid = 1'b1; upd_idx = 8'h10; upd_taken = 1'b1;
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      pat = {pat[4:0], upd_ready};
      @(negedge clk);
    end
    upd_valid = 1'b0;
    n_up += 3;
    chk("upd_ready_pattern", {26'h0, pat}, 32'h2A);
    @(negedge clk);
    do_lookup(8'h10, 8'h07);

    // Ordering and forwarding around one update to 0x22.
    chk("fwd_ready", {30'h0, lookup_ready, upd_ready}, 32'h3);
    upd_valid = 1'b1; upd_idx = 8'h22; upd_taken = 1'b1;
    n_up++;
    lookup_valid = 1'b1; lookup_idx = 8'h22; sb.push_back(8'h00); n_lk++;
    @(negedge clk);
    upd_valid = 1'b0;
    sb.push_back(8'h01); n_lk++;
    @(negedge clk);
    sb.push_back(8'h01); n_lk++;
    @(negedge clk);
    lookup_valid = 1'b0;
    @(negedge clk);
`ifdef LHT_CTRL_PERF_EN
    chk("perf_fwd_cnt", perf_fwd_cnt, 32'd1);
`endif

    // Concurrent lookup and update.
    chk("conc_ready", {30'h0, lookup_ready, upd_ready}, 32'h3);
    upd_valid = 1'b1; upd_idx = 8'h31; upd_taken = 1'b1;
    n_up++;
    lookup_valid = 1'b1; lookup_idx = 8'h30; sb.push_back(8'h00); n_lk++;
    @(negedge clk);
    upd_valid = 1'b0;
    lookup_valid = 1'b0;
    chk("conc_resp_valid", {31'h0, resp_valid}, 32'h1);

    // Nine taken then one not-taken.
    for (int i = 0; i < 9; i++) do_update(8'h44, 1'b1);
    do_update(8'h44, 1'b0);
    repeat (2) @(negedge clk);

    // Back-to-back lookups from the table.
    for (int i = 0; i < 7; i++) begin
      lookup_valid = 1'b1;
      lookup_idx   = vecs[i].idx;
      sb.push_back(vecs[i].exp);
      n_lk++;
      @(negedge clk);
    end
    lookup_valid = 1'b0;
    repeat (2) @(negedge clk);
`ifdef LHT_CTRL_PERF_EN
    chk("perf_lookup_cnt", perf_lookup_cnt, n_lk);
    chk("perf_upd_cnt", perf_upd_cnt, n_up);
`endif
    chk("sb_drained_pre_rst", sb.size(), 0);

    // Reset in the middle of an update's write cycle.
    do_update(8'h55, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_in_uwr_idle", {30'h0, csb1, web1}, 32'h3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reinit_first_cmd", {22'h0, csb1, web1, addr1}, 32'h0);
`ifdef LHT_CTRL_PERF_EN
    chk("reinit_perf", perf_lookup_cnt | perf_upd_cnt | perf_fwd_cnt, 32'h0);
`endif
    wait_init("reinit");
    @(negedge clk);
    do_lookup(8'h55, 8'h00);
    repeat (3) @(negedge clk);
    chk("no_write_0x55", bad55, 0);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
